sha256_run_sched: RTL and testbench

//  Top-level sequencer for one SHA256 block computation. Reloads H SRAM with the initial hash constants,

---
 rtl/sha256_pkg.sv | 46 ++++
 rtl/sha256_run_sched_if.sv | 16 +
 rtl/sha256_hmem_arb.sv | 65 ++++++
 rtl/sha256_run_sched.sv | 157 +++++++++++++++
 tb/tb_sha256_run_sched.sv | 398 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants: initial hash words, H SRAM geometry and sequencer state encoding.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
// Contents: WORD_W/H_ADDR_W widths, default sequencer limits, state_t, h_init() lookup.
package sha256_pkg;

  localparam int WORD_W            = 32;
  localparam int NUM_H             = 8;
  localparam int H_ADDR_W          = $clog2(NUM_H);
  localparam int DEF_MAX_MSG_LEN   = 55;
  localparam int DEF_STAGE_TIMEOUT = 1024;

  // Sequencer state encoding, kept explicit so the hash core and debug views agree on it.
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_HINIT = 3'd1;
  localparam logic [2:0] ST_PAD   = 3'd2;
  localparam logic [2:0] ST_WGEN  = 3'd3;
  localparam logic [2:0] ST_HASH  = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;
  localparam logic [2:0] ST_ERR   = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE,
    S_HINIT = ST_HINIT,
    S_PAD   = ST_PAD,
    S_WGEN  = ST_WGEN,
    S_HASH  = ST_HASH,
    S_DONE  = ST_DONE,
    S_ERR   = ST_ERR
  } state_t;

  // SHA-256 initial hash value H(0), indexed by H SRAM address.
  function automatic logic [WORD_W-1:0] h_init(input logic [H_ADDR_W-1:0] idx);
    case (idx)
      3'd0:    h_init = 32'h6a09e667;
      3'd1:    h_init = 32'hbb67ae85;
      3'd2:    h_init = 32'h3c6ef372;
      3'd3:    h_init = 32'ha54ff53a;
      3'd4:    h_init = 32'h510e527f;
      3'd5:    h_init = 32'h9b05688c;
      3'd6:    h_init = 32'h1f83d9ab;
      default: h_init = 32'h5be0cd19;
    endcase
  endfunction

endpackage

// File: rtl/sha256_run_sched_if.sv
// Single-port H SRAM request bundle (enable, read/write, address, write data).
// Latency: none (wires only).
// Backpressure: none; the requester owns the port only while its arbiter selects it.
// Modports: master drives the request, slave receives it.
interface sha256_run_sched_if;
  import sha256_pkg::*;

  logic                en;
  logic                rw;     // 1 = write, 0 = read
  logic [H_ADDR_W-1:0] addr;
  logic [WORD_W-1:0]   wdata;

  modport master (output en, rw, addr, wdata);
  modport slave  (input  en, rw, addr, wdata);

endinterface

// File: rtl/sha256_hmem_arb.sv
// H SRAM port mux: init writes in HINIT, hash core in PAD/WGEN/HASH, host reads in IDLE/DONE/ERR.
// Latency: mux is combinational; host_h_rvld follows host_h_gnt by one cycle (SRAM read latency).
// Backpressure: host request is simply not granted in busy states and must be held until granted.
// Ports: clock/reset, state (sequencer state register), init_addr, core_h (in), host_h_req/addr (in),
//        h_mem (out), host_h_gnt/host_h_rvld (out).
module sha256_hmem_arb
  import sha256_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  state_t              state,
  input  logic [H_ADDR_W-1:0] init_addr,
  sha256_run_sched_if.slave   core_h,
  input  logic                host_h_req,
  input  logic [H_ADDR_W-1:0] host_h_addr,
  sha256_run_sched_if.master  h_mem,
  output logic                host_h_gnt,
  output logic                host_h_rvld
);

  logic live;      // low while reset is held and for the first cycle after, so no output leaks out of reset
  logic host_sel;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      live        <= 1'b0;
      host_h_rvld <= 1'b0;
    end else begin
      live        <= 1'b1;
      host_h_rvld <= host_h_gnt;
    end
  end

  always_comb begin
    h_mem.en    = 1'b0;
    h_mem.rw    = 1'b0;
    h_mem.addr  = '0;
    h_mem.wdata = '0;
    host_sel    = 1'b0;
    case (state)
      S_HINIT: begin
        h_mem.en    = 1'b1;
        h_mem.rw    = 1'b1;
        h_mem.addr  = init_addr;
        h_mem.wdata = h_init(init_addr);
      end
      S_PAD, S_WGEN, S_HASH: begin
        h_mem.en    = core_h.en;
        h_mem.rw    = core_h.rw;
        h_mem.addr  = core_h.addr;
        h_mem.wdata = core_h.wdata;
      end
      S_IDLE, S_DONE, S_ERR: host_sel = live;
      default: host_sel = 1'b0;
    endcase
    // Host only ever reads; rw stays 0 from the defaults.
    if (host_sel) begin
      h_mem.en   = host_h_req;
      h_mem.addr = host_h_addr;
    end
  end

  assign host_h_gnt = host_sel & host_h_req;

endmodule

// File: rtl/sha256_run_sched.sv
// Sequences one SHA-256 block: reload H SRAM with H(0), then fire pad / W / hash stage go pulses in order.
// Latency: pad_go 9 cycles after an accepted go; w_go / h_go one cycle after pad_rdy / w_rdy; finish one cycle after h_finish.
// Backpressure: go ignored while busy; stage pulses outside their state are ignored; host H reads wait until not busy.
// Ports: clock/reset; main_go_sig/msg_len; pad_rdy/w_rdy/h_finish; regop_*_go pulses; core_h (in);
//        host_h_req/addr (in); h_mem (out); host_h_gnt/rvld; busy; regop_finish/regop_err (sticky).
module sha256_run_sched
  import sha256_pkg::*;
#(
  parameter int MAX_MESSAGE_LENGTH = DEF_MAX_MSG_LEN,
  parameter int NUMBER_OF_Hs       = NUM_H,
  parameter int STAGE_TIMEOUT      = DEF_STAGE_TIMEOUT
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic                                  main_go_sig,
  input  logic [$clog2(MAX_MESSAGE_LENGTH)-1:0] msg_len,
  input  logic                                  pad_rdy,
  input  logic                                  w_rdy,
  input  logic                                  h_finish,
  output logic                                  regop_pad_go,
  output logic                                  regop_w_go,
  output logic                                  regop_h_go,
  sha256_run_sched_if.slave                     core_h,
  input  logic                                  host_h_req,
  input  logic [H_ADDR_W-1:0]                   host_h_addr,
  sha256_run_sched_if.master                    h_mem,
  output logic                                  host_h_gnt,
  output logic                                  host_h_rvld,
  output logic                                  busy,
  output logic                                  regop_finish,
  output logic                                  regop_err
);

  localparam int MSG_LEN_W = $clog2(MAX_MESSAGE_LENGTH);
  localparam int WDOG_W    = $clog2(STAGE_TIMEOUT);

  localparam logic [MSG_LEN_W-1:0] MAX_LEN    = MSG_LEN_W'(MAX_MESSAGE_LENGTH);
  localparam logic [H_ADDR_W-1:0]  LAST_H     = H_ADDR_W'(NUMBER_OF_Hs - 1);
  localparam logic [WDOG_W-1:0]    WDOG_LIMIT = WDOG_W'(STAGE_TIMEOUT - 1);

  state_t              state_q, state_d;
  logic [H_ADDR_W-1:0] init_idx_q, init_idx_d;
  logic [WDOG_W-1:0]   wdog_q, wdog_d;
  logic                pad_go_d, w_go_d, h_go_d;
  logic                finish_q, finish_d;
  logic                err_q, err_d;
  logic                waiting;

  assign waiting = (state_q == S_PAD) || (state_q == S_WGEN) || (state_q == S_HASH);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      init_idx_q   <= '0;
      wdog_q       <= '0;
      regop_pad_go <= 1'b0;
      regop_w_go   <= 1'b0;
      regop_h_go   <= 1'b0;
      finish_q     <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      init_idx_q   <= init_idx_d;
      wdog_q       <= wdog_d;
      regop_pad_go <= pad_go_d;
      regop_w_go   <= w_go_d;
      regop_h_go   <= h_go_d;
      finish_q     <= finish_d;
      err_q        <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    init_idx_d = init_idx_q;
    wdog_d     = '0;
    pad_go_d   = 1'b0;
    w_go_d     = 1'b0;
    h_go_d     = 1'b0;
    finish_d   = finish_q;
    err_d      = err_q;

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (main_go_sig) begin
          finish_d   = 1'b0;
          err_d      = 1'b0;
          init_idx_d = '0;
          if (msg_len > MAX_LEN) begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end else begin
            state_d = S_HINIT;
          end
        end
      end
      S_HINIT: begin
        // The pad go leaves with the state change so it lands on the cycle after the last write.
        if (init_idx_q == LAST_H) begin
          state_d  = S_PAD;
          pad_go_d = 1'b1;
        end else begin
          init_idx_d = init_idx_q + H_ADDR_W'(1);
        end
      end
      S_PAD: begin
        if (pad_rdy) begin
          state_d = S_WGEN;
          w_go_d  = 1'b1;
        end
      end
      S_WGEN: begin
        if (w_rdy) begin
          state_d = S_HASH;
          h_go_d  = 1'b1;
        end
      end
      S_HASH: begin
        if (h_finish) begin
          state_d  = S_DONE;
          finish_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Watchdog: runs only while parked in a waiting state; any state change leaves it cleared.
    // A stage completing in the same cycle as the limit wins over the timeout.
    // The >= compare keeps it from wrapping even if the limit is ever the counter's max value.
    if (waiting && (state_d == state_q)) begin
      if (wdog_q >= WDOG_LIMIT) begin
        state_d = S_ERR;
        err_d   = 1'b1;
      end else begin
        wdog_d = wdog_q + WDOG_W'(1);
      end
    end
  end

  assign busy         = (state_q == S_HINIT) || waiting;
  assign regop_finish = finish_q;
  assign regop_err    = err_q;

  sha256_hmem_arb u_arb (
    .clock       (clock),
    .reset       (reset),
    .state       (state_q),
    .init_addr   (init_idx_q),
    .core_h      (core_h),
    .host_h_req  (host_h_req),
    .host_h_addr (host_h_addr),
    .h_mem       (h_mem),
    .host_h_gnt  (host_h_gnt),
    .host_h_rvld (host_h_rvld)
  );

endmodule

// File: tb/tb_sha256_run_sched.sv
// Self-checking bench for the SHA-256 run sequencer with a behavioural H SRAM and stage responders.
// Latency: n/a.
// Backpressure: n/a.
module tb_sha256_run_sched;

  localparam int T_OUT = 1024;
  localparam logic [31:0] H_REF [8] = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

  logic       clock = 1'b0;
  logic       reset;
  logic       main_go_sig, pad_rdy, w_rdy, h_finish;
  logic [5:0] msg_len;
  logic       regop_pad_go, regop_w_go, regop_h_go;
  logic       host_h_req;
  logic [2:0] host_h_addr;
  logic       host_h_gnt, host_h_rvld, busy, regop_finish, regop_err;

  sha256_run_sched_if core_h_if ();
  sha256_run_sched_if h_mem_if ();

  always #5 clock = ~clock;

  sha256_run_sched dut (
    .clock        (clock),
    .reset        (reset),
    .main_go_sig  (main_go_sig),
    .msg_len      (msg_len),
    .pad_rdy      (pad_rdy),
    .w_rdy        (w_rdy),
    .h_finish     (h_finish),
    .regop_pad_go (regop_pad_go),
    .regop_w_go   (regop_w_go),
    .regop_h_go   (regop_h_go),
    .core_h       (core_h_if),
    .host_h_req   (host_h_req),
    .host_h_addr  (host_h_addr),
    .h_mem        (h_mem_if),
    .host_h_gnt   (host_h_gnt),
    .host_h_rvld  (host_h_rvld),
    .busy         (busy),
    .regop_finish (regop_finish),
    .regop_err    (regop_err)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Behavioural single-port H SRAM, one-cycle read latency; scramble preloads a known non-H(0) pattern.
  logic [31:0] mem [8];
  logic [31:0] rdata;
  logic        scramble = 1'b0;
  logic [31:0] exp_h [8];

  function automatic logic [31:0] scr_word(input int i);
    return 32'hc0de0000 + 32'(i);
  endfunction

  always @(posedge clock) begin
    if (scramble) begin
      for (int i = 0; i < 8; i++) mem[i] <= scr_word(i);
    end else if (h_mem_if.en === 1'b1) begin
      if (h_mem_if.rw) mem[h_mem_if.addr] <= h_mem_if.wdata;
      else rdata <= mem[h_mem_if.addr];
    end
  end

  // Event monitor: counts stage pulses and SRAM writes.
  int n_pad = 0, n_w = 0, n_h = 0, n_wr = 0;
  always @(negedge clock) begin
    if (regop_pad_go === 1'b1) n_pad <= n_pad + 1;
    if (regop_w_go === 1'b1) n_w <= n_w + 1;
    if (regop_h_go === 1'b1) n_h <= n_h + 1;
    if (h_mem_if.en === 1'b1 && h_mem_if.rw === 1'b1) n_wr <= n_wr + 1;
  end

  function automatic int hinit_diffs();
    int d = 0;
    for (int i = 0; i < 8; i++) if (mem[i] !== H_REF[i]) d++;
    return d;
  endfunction

  task automatic step();
    @(negedge clock);
    #1;
  endtask

  task automatic do_go(input logic [5:0] len, output int g);
    g = cyc;
    msg_len = len;
    main_go_sig = 1'b1;
    step();
    main_go_sig = 1'b0;
  endtask

  // Entered on cycle go+1: expect 8 init writes, then pad_go on go+9 with H(0) in the SRAM.
  task automatic check_hinit(input int g);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if ({regop_pad_go, h_mem_if.en, h_mem_if.rw, h_mem_if.addr, h_mem_if.wdata} !==
          {1'b0, 1'b1, 1'b1, 3'(i), H_REF[i]}) begin
        errors++;
        $display("FAIL hinit_write[%0d]: got en=%b rw=%b addr=%0d wdata=%h pad_go=%b want 1 1 %0d %h 0",
                 i, h_mem_if.en, h_mem_if.rw, h_mem_if.addr, h_mem_if.wdata, regop_pad_go, i, H_REF[i]);
      end
      step();
    end
    checks++;
    if (regop_pad_go !== 1'b1 || cyc != g + 9) begin
      errors++;
      $display("FAIL pad_go_at_go+9: got pad_go=%b at cycle %0d want 1 at %0d", regop_pad_go, cyc, g + 9);
    end
    checks++;
    if (hinit_diffs() != 0) begin
      errors++;
      $display("FAIL hinit_contents: got %0d wrong words want 0", hinit_diffs());
    end
    for (int i = 0; i < 8; i++) exp_h[i] = H_REF[i];
  endtask

  // Entered on the pad_go cycle. Drives pad_rdy/w_rdy/h_finish after pd/wd/hd cycles.
  task automatic run_stages(input int pd, input int wd, input int hd, input bit host3, input bit stray);
    int np0, nw0, nh0, pass_bad, gnt_bad;
    np0 = n_pad; nw0 = n_w; nh0 = n_h;
    pass_bad = 0; gnt_bad = 0;
    repeat (pd) step();
    pad_rdy = 1'b1;
    step();
    pad_rdy = 1'b0;
    checks++;
    if ({regop_w_go, regop_h_go, busy} !== 3'b101) begin
      errors++;
      $display("FAIL w_go_after_pad_rdy: got w_go=%b h_go=%b busy=%b want 1 0 1", regop_w_go, regop_h_go, busy);
    end
    repeat (wd) step();
    w_rdy = 1'b1;
    step();
    w_rdy = 1'b0;
    checks++;
    if (regop_h_go !== 1'b1) begin
      errors++;
      $display("FAIL h_go_after_w_rdy: got %b want 1", regop_h_go);
    end
    checks++;
    if (hinit_diffs() != 0) begin
      errors++;
      $display("FAIL hinit_before_hash: got %0d wrong words want 0", hinit_diffs());
    end
    if (host3) begin
      host_h_req = 1'b1;
      host_h_addr = 3'd3;
    end
    for (int k = 0; k < hd; k++) begin
      if (host_h_gnt !== 1'b0) gnt_bad++;
      core_h_if.en = (k == 0) || ($urandom_range(0, 3) == 0);
      core_h_if.rw = 1'b1;
      core_h_if.addr = (k == 0) ? 3'd3 : 3'($urandom_range(0, 7));
      core_h_if.wdata = $urandom;
      pad_rdy = stray && (k == hd / 2);
      w_rdy = stray && (k == hd / 2);
      main_go_sig = stray && (k == hd / 2);
      #1;
      if ({h_mem_if.en, h_mem_if.rw, h_mem_if.addr, h_mem_if.wdata} !==
          {core_h_if.en, core_h_if.rw, core_h_if.addr, core_h_if.wdata}) pass_bad++;
      if (core_h_if.en) exp_h[core_h_if.addr] = core_h_if.wdata;
      step();
    end
    core_h_if.en = 1'b0;
    pad_rdy = 1'b0; w_rdy = 1'b0; main_go_sig = 1'b0;
    checks++;
    if (pass_bad != 0) begin
      errors++;
      $display("FAIL core_passthrough: got %0d mismatching cycles want 0", pass_bad);
    end
    checks++;
    if (gnt_bad != 0) begin
      errors++;
      $display("FAIL host_blocked_in_hash: got %0d granted cycles want 0", gnt_bad);
    end
    h_finish = 1'b1;
    step();
    h_finish = 1'b0;
    checks++;
    if ({regop_finish, busy, regop_err} !== 3'b100) begin
      errors++;
      $display("FAIL finish_after_h_finish: got fin=%b busy=%b err=%b want 1 0 0", regop_finish, busy, regop_err);
    end
    checks++;
    if ((n_pad - np0) != 0 || (n_w - nw0) != 1 || (n_h - nh0) != 1) begin
      errors++;
      $display("FAIL pulse_counts: got pad=%0d w=%0d h=%0d want 0 1 1", n_pad - np0, n_w - nw0, n_h - nh0);
    end
    if (host3) begin
      checks++;
      if ({host_h_gnt, h_mem_if.en, h_mem_if.rw, h_mem_if.addr} !== {1'b1, 1'b1, 1'b0, 3'd3}) begin
        errors++;
        $display("FAIL host_gnt_first_done: got gnt=%b en=%b rw=%b addr=%0d want 1 1 0 3",
                 host_h_gnt, h_mem_if.en, h_mem_if.rw, h_mem_if.addr);
      end
      step();
      host_h_req = 1'b0;
      checks++;
      if (host_h_rvld !== 1'b1 || rdata !== exp_h[3]) begin
        errors++;
        $display("FAIL host_read_h3: got rvld=%b data=%h want 1 %h", host_h_rvld, rdata, exp_h[3]);
      end
      step();
      checks++;
      if (host_h_rvld !== 1'b0) begin
        errors++;
        $display("FAIL host_rvld_drop: got %b want 0", host_h_rvld);
      end
    end
  endtask

  task automatic test_reset();
    step();
    step();
    checks++;
    if ({regop_pad_go, regop_w_go, regop_h_go, busy, regop_finish, regop_err,
         host_h_gnt, host_h_rvld, h_mem_if.en} !== 9'b0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b fin=%b err=%b en=%b want all 0",
               busy, regop_finish, regop_err, h_mem_if.en);
    end
    reset = 1'b1;
    scramble = 1'b1;
    step();
    scramble = 1'b0;
    step();
    checks++;
    if ({busy, regop_err, regop_finish} !== 3'b000) begin
      errors++;
      $display("FAIL idle_after_release: got busy=%b err=%b fin=%b want 0 0 0", busy, regop_err, regop_finish);
    end
  endtask

  task automatic test_normal_run();
    int g;
    do_go(6'd7, g);
    checks++;
    if ({busy, regop_finish, regop_err} !== 3'b100) begin
      errors++;
      $display("FAIL busy_after_go: got busy=%b fin=%b err=%b want 1 0 0", busy, regop_finish, regop_err);
    end
    check_hinit(g);
    // pad_rdy at go+20, w_rdy at go+70, h_finish at go+600.
    run_stages(11, 49, 529, 1'b1, 1'b0);
  endtask

  task automatic test_bad_length();
    int g, np0, nw0, d;
    logic [31:0] snap [8];
    for (int i = 0; i < 8; i++) snap[i] = mem[i];
    np0 = n_pad;
    nw0 = n_wr;
    do_go(6'd60, g);
    checks++;
    if ({regop_err, busy, regop_finish} !== 3'b100) begin
      errors++;
      $display("FAIL len60_err_at_go+1: got err=%b busy=%b fin=%b want 1 0 0", regop_err, busy, regop_finish);
    end
    repeat (12) step();
    d = 0;
    for (int i = 0; i < 8; i++) if (mem[i] !== snap[i]) d++;
    checks++;
    if (n_pad != np0 || n_wr != nw0 || d != 0) begin
      errors++;
      $display("FAIL len60_no_activity: got pad_go=%0d writes=%0d changed=%0d want 0 0 0", n_pad - np0, n_wr - nw0, d);
    end
    do_go(6'($urandom_range(56, 63)), g);
    checks++;
    if ({regop_err, busy} !== 2'b10) begin
      errors++;
      $display("FAIL random_bad_len_err: got err=%b busy=%b want 1 0", regop_err, busy);
    end
  endtask

  task automatic test_timeout();
    int g, wc, n, nh0;
    do_go(6'd55, g);
    checks++;
    if ({regop_err, busy} !== 2'b01) begin
      errors++;
      $display("FAIL len55_accepted: got err=%b busy=%b want 0 1", regop_err, busy);
    end
    check_hinit(g);
    repeat ($urandom_range(0, 30)) step();
    pad_rdy = 1'b1;
    step();
    pad_rdy = 1'b0;
    wc = cyc;
    nh0 = n_h;
    n = 0;
    while (regop_err !== 1'b1 && n < T_OUT + 64) begin
      step();
      n++;
    end
    checks++;
    if (regop_err !== 1'b1 || cyc - wc != T_OUT) begin
      errors++;
      $display("FAIL wgen_timeout: got err=%b after %0d cycles want 1 after %0d", regop_err, cyc - wc, T_OUT);
    end
    checks++;
    if (busy !== 1'b0 || n_h != nh0) begin
      errors++;
      $display("FAIL timeout_idle: got busy=%b h_go=%0d want 0 0", busy, n_h - nh0);
    end
    do_go(6'($urandom_range(0, 55)), g);
    checks++;
    if ({regop_err, busy} !== 2'b01) begin
      errors++;
      $display("FAIL restart_clears_err: got err=%b busy=%b want 0 1", regop_err, busy);
    end
    check_hinit(g);
    run_stages($urandom_range(0, 40), $urandom_range(0, 100), $urandom_range(1, 300), 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    int g;
    do_go(6'($urandom_range(0, 55)), g);
    check_hinit(g);
    // Go, pad_rdy and w_rdy strobed mid-HASH must all be ignored.
    run_stages($urandom_range(0, 40), $urandom_range(0, 100), $urandom_range(10, 300), 1'b1, 1'b1);
    do_go(6'($urandom_range(0, 55)), g);
    checks++;
    if ({regop_finish, busy} !== 2'b01) begin
      errors++;
      $display("FAIL go_in_done_clears_finish: got fin=%b busy=%b want 0 1", regop_finish, busy);
    end
    check_hinit(g);
    run_stages($urandom_range(0, 40), $urandom_range(0, 100), $urandom_range(1, 300), 1'b1, 1'b0);
  endtask

  task automatic test_reset_mid_hinit();
    int g, d;
    scramble = 1'b1;
    step();
    scramble = 1'b0;
    do_go(6'($urandom_range(0, 55)), g);
    repeat (4) step();
    checks++;
    if ({h_mem_if.en, h_mem_if.rw, h_mem_if.addr} !== {1'b1, 1'b1, 3'd4}) begin
      errors++;
      $display("FAIL hinit_write4: got en=%b rw=%b addr=%0d want 1 1 4", h_mem_if.en, h_mem_if.rw, h_mem_if.addr);
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({regop_pad_go, regop_w_go, regop_h_go, busy, regop_finish, regop_err,
         host_h_gnt, host_h_rvld, h_mem_if.en} !== 9'b0) begin
      errors++;
      $display("FAIL async_reset_outputs: got busy=%b en=%b fin=%b err=%b want all 0",
               busy, h_mem_if.en, regop_finish, regop_err);
    end
    step();
    step();
    reset = 1'b1;
    step();
    step();
    d = 0;
    for (int i = 0; i < 8; i++) if (mem[i] !== ((i < 4) ? H_REF[i] : scr_word(i))) d++;
    checks++;
    if (busy !== 1'b0 || d != 0) begin
      errors++;
      $display("FAIL no_writes_after_reset: got busy=%b wrong_words=%0d want 0 0", busy, d);
    end
    do_go(6'($urandom_range(0, 55)), g);
    check_hinit(g);
    run_stages($urandom_range(0, 40), $urandom_range(0, 100), $urandom_range(1, 300), 1'b1, 1'b0);
  endtask

  initial begin
    reset = 1'b0;
    main_go_sig = 1'b0;
    msg_len = '0;
    pad_rdy = 1'b0;
    w_rdy = 1'b0;
    h_finish = 1'b0;
    host_h_req = 1'b0;
    host_h_addr = '0;
    core_h_if.en = 1'b0;
    core_h_if.rw = 1'b0;
    core_h_if.addr = '0;
    core_h_if.wdata = '0;
    test_reset();
    test_normal_run();
    test_bad_length();
    test_timeout();
    test_back_to_back();
    test_reset_mid_hinit();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
